// File: rtl/c4_pkg.sv
// Shared constants, types and grid-offset helpers for the connect-four engine.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
package c4_pkg;

  localparam int ROWS      = 6;
  localparam int COLS      = 7;
  localparam int GRID_W    = 98;
  localparam int MAX_MOVES = 42;

  localparam logic [1:0] EMPTY = 2'b00;
  localparam logic [1:0] P1    = 2'b01;
  localparam logic [1:0] P2    = 2'b10;

  typedef enum logic [2:0] {
    SELECT,
    FALL,
    CHECK,
    WIN,
    DRAW
  } state_t;

  // Row 0 / column 0 is the leftmost (most significant) element, matching the
  // order in which the display stage scans the grid bus.
  typedef logic [0:ROWS-1][0:COLS-1][1:0] board_t;

  // MSB position of selector-row column c on the grid bus.
  function automatic int sel_hi(input logic [2:0] c);
    return 97 - 2 * int'(c);
  endfunction

  // MSB position of board cell (r, c) on the grid bus.
  function automatic int cell_hi(input logic [2:0] r, input logic [2:0] c);
    return 83 - 14 * int'(r) - 2 * int'(c);
  endfunction

endpackage

// File: rtl/c4_run_count.sv
// Counts the run of same-coloured cells through an anchor cell along one direction.
// Latency: purely combinational.
// Backpressure: none; output follows inputs.
module c4_run_count
  import c4_pkg::*;
#(
  parameter int WIN_LEN = 4
) (
  input  board_t     i_board,
  input  logic [2:0] i_row,
  input  logic [2:0] i_col,
  input  logic [1:0] i_dir,
  input  logic [1:0] i_code,
  output logic [3:0] o_run
);

  int         w_dr;
  int         w_dc;
  int         w_r;
  int         w_c;
  logic       w_fwd_go;
  logic       w_bwd_go;
  logic [3:0] w_run;

  // Walk forward then backward from the anchor, each side capped at WIN_LEN-1.
  always_comb begin
    w_dr     = 0;
    w_dc     = 1;
    w_r      = 0;
    w_c      = 0;
    w_fwd_go = 1'b1;
    w_bwd_go = 1'b1;
    w_run    = 4'd1;
    case (i_dir)
      2'd0:    begin w_dr = 0;  w_dc = 1; end  // horizontal
      2'd1:    begin w_dr = 1;  w_dc = 0; end  // vertical
      2'd2:    begin w_dr = 1;  w_dc = 1; end  // down-right
      default: begin w_dr = -1; w_dc = 1; end  // up-right
    endcase
    for (int k = 1; k < WIN_LEN; k++) begin
      w_r = int'(i_row) + k * w_dr;
      w_c = int'(i_col) + k * w_dc;
      if (w_fwd_go && (w_r >= 0) && (w_r < ROWS) && (w_c >= 0) && (w_c < COLS) &&
          (i_board[w_r[2:0]][w_c[2:0]] == i_code)) begin
        w_run = w_run + 4'd1;
      end else begin
        w_fwd_go = 1'b0;
      end
    end
    for (int k = 1; k < WIN_LEN; k++) begin
      w_r = int'(i_row) - k * w_dr;
      w_c = int'(i_col) - k * w_dc;
      if (w_bwd_go && (w_r >= 0) && (w_r < ROWS) && (w_c >= 0) && (w_c < COLS) &&
          (i_board[w_r[2:0]][w_c[2:0]] == i_code)) begin
        w_run = w_run + 4'd1;
      end else begin
        w_bwd_go = 1'b0;
      end
    end
  end

  assign o_run = w_run;

endmodule

// File: rtl/c4_game_ctrl.sv
// Connect-four engine: board, selector, turns, fall animation, win/draw; drives grid bus.
// Latency: grid is registered and reflects the new state one clock after the causing input.
// Backpressure: none; pulses arriving in states that do not use them are dropped.
// Optional build macro C4_SELECT_WRAP_EN: selector wraps 0<->6 instead of saturating.
module c4_game_ctrl
  import c4_pkg::*;
#(
  parameter int START_COL = 3,
  parameter int WIN_LEN   = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              btn_left,
  input  logic              btn_right,
  input  logic              btn_drop,
  input  logic              step_tick,
  output logic [GRID_W-1:0] grid,
  output logic [1:0]        winner,
  output logic              game_over,
  output logic              busy
);

  localparam logic [2:0]        L_START    = 3'(START_COL);
  localparam logic [2:0]        L_LAST_COL = 3'(COLS - 1);
  localparam logic [GRID_W-1:0] L_GRID_RST = {{(GRID_W-2){1'b0}}, P1} << (96 - 2 * START_COL);

  state_t            r_state,      w_state_nxt;
  board_t            r_board,      w_board_nxt;
  logic [1:0]        r_player,     w_player_nxt;
  logic [2:0]        r_sel_col,    w_sel_col_nxt;
  logic [2:0]        r_fall_row,   w_fall_row_nxt;
  logic [1:0]        r_dir,        w_dir_nxt;
  logic              r_win_flag,   w_win_flag_nxt;
  logic [1:0]        r_winner,     w_winner_nxt;
  logic [5:0]        r_move_count, w_move_count_nxt;
  logic [GRID_W-1:0] r_grid,       w_grid_nxt;
  logic [3:0]        w_run;
  logic              w_hit;

  // Run length through the last committed piece along the direction under test.
  c4_run_count #(
    .WIN_LEN (WIN_LEN)
  ) u_run_count (
    .i_board (r_board),
    .i_row   (r_fall_row),
    .i_col   (r_sel_col),
    .i_dir   (r_dir),
    .i_code  (r_player),
    .o_run   (w_run)
  );

  assign w_hit = (w_run >= 4'(WIN_LEN));

  // State register: all game state, cleared by async reset (drops any in-flight piece).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= SELECT;
      r_board      <= '0;
      r_player     <= P1;
      r_sel_col    <= L_START;
      r_fall_row   <= 3'd0;
      r_dir        <= 2'd0;
      r_win_flag   <= 1'b0;
      r_winner     <= EMPTY;
      r_move_count <= 6'd0;
      r_grid       <= L_GRID_RST;
    end else begin
      r_state      <= w_state_nxt;
      r_board      <= w_board_nxt;
      r_player     <= w_player_nxt;
      r_sel_col    <= w_sel_col_nxt;
      r_fall_row   <= w_fall_row_nxt;
      r_dir        <= w_dir_nxt;
      r_win_flag   <= w_win_flag_nxt;
      r_winner     <= w_winner_nxt;
      r_move_count <= w_move_count_nxt;
      r_grid       <= w_grid_nxt;
    end
  end

  // Next-state logic: selector moves, drop, fall stepping, 4-cycle direction scan, restart.
  always_comb begin
    w_state_nxt      = r_state;
    w_board_nxt      = r_board;
    w_player_nxt     = r_player;
    w_sel_col_nxt    = r_sel_col;
    w_fall_row_nxt   = r_fall_row;
    w_dir_nxt        = r_dir;
    w_win_flag_nxt   = r_win_flag;
    w_winner_nxt     = r_winner;
    w_move_count_nxt = r_move_count;
    case (r_state)
      SELECT: begin
        if (btn_drop) begin
          // A full column swallows the drop without changing anything.
          if (r_board[0][r_sel_col] == EMPTY) begin
            w_fall_row_nxt = 3'd0;
            w_state_nxt    = FALL;
          end
        end else if (btn_left && !btn_right) begin
`ifdef C4_SELECT_WRAP_EN
          w_sel_col_nxt = (r_sel_col == 3'd0) ? L_LAST_COL : r_sel_col - 3'd1;
`else
          if (r_sel_col != 3'd0) begin
            w_sel_col_nxt = r_sel_col - 3'd1;
          end
`endif
        end else if (btn_right && !btn_left) begin
`ifdef C4_SELECT_WRAP_EN
          w_sel_col_nxt = (r_sel_col == L_LAST_COL) ? 3'd0 : r_sel_col + 3'd1;
`else
          if (r_sel_col != L_LAST_COL) begin
            w_sel_col_nxt = r_sel_col + 3'd1;
          end
`endif
        end
      end
      FALL: begin
        if (step_tick) begin
          if ((r_fall_row < 3'd5) && (r_board[r_fall_row + 3'd1][r_sel_col] == EMPTY)) begin
            w_fall_row_nxt = r_fall_row + 3'd1;
          end else begin
            w_board_nxt[r_fall_row][r_sel_col] = r_player;
            w_move_count_nxt = r_move_count + 6'd1;
            w_dir_nxt        = 2'd0;
            w_win_flag_nxt   = 1'b0;
            w_state_nxt      = CHECK;
          end
        end
      end
      CHECK: begin
        w_dir_nxt = r_dir + 2'd1;
        if (w_hit) begin
          w_win_flag_nxt = 1'b1;
        end
        if (r_dir == 2'd3) begin
          if (r_win_flag || w_hit) begin
            w_winner_nxt = r_player;
            w_state_nxt  = WIN;
          end else if (r_move_count == 6'(MAX_MOVES)) begin
            w_state_nxt = DRAW;
          end else begin
            w_player_nxt = r_player ^ 2'b11;
            w_state_nxt  = SELECT;
          end
        end
      end
      WIN, DRAW: begin
        if (btn_drop) begin
          w_board_nxt      = '0;
          w_winner_nxt     = EMPTY;
          w_move_count_nxt = 6'd0;
          w_win_flag_nxt   = 1'b0;
          w_player_nxt     = P1;
          w_sel_col_nxt    = L_START;
          w_state_nxt      = SELECT;
        end
      end
      default: begin
        w_state_nxt = SELECT;
      end
    endcase
  end

  // Render the grid from next-state values so the registered bus matches the state register.
  always_comb begin
    w_grid_nxt = '0;
    for (int r = 0; r < ROWS; r++) begin
      for (int c = 0; c < COLS; c++) begin
        w_grid_nxt[cell_hi(3'(r), 3'(c)) -: 2] = w_board_nxt[r][c];
      end
    end
    if (w_state_nxt == SELECT) begin
      w_grid_nxt[sel_hi(w_sel_col_nxt) -: 2] = w_player_nxt;
    end else if (w_state_nxt == FALL) begin
      w_grid_nxt[cell_hi(w_fall_row_nxt, w_sel_col_nxt) -: 2] = w_player_nxt;
    end
  end

  assign grid      = r_grid;
  assign winner    = r_winner;
  assign game_over = (r_state == WIN) || (r_state == DRAW);
  assign busy      = (r_state == FALL) || (r_state == CHECK);

endmodule

// File: tb/tb_c4_game_ctrl.sv
// Directed bench for c4_game_ctrl with a small board model for expected grids.
// Latency: samples outputs on the falling edge after each driven rising edge.
// Backpressure: n/a.
module tb_c4_game_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        btn_left = 1'b0;
  logic        btn_right = 1'b0;
  logic        btn_drop = 1'b0;
  logic        step_tick = 1'b0;
  logic [97:0] grid;
  logic [1:0]  winner;
  logic        game_over;
  logic        busy;

  int checks = 0;
  int failures = 0;

  logic [1:0] m_board [6][7];
  int         m_h [7];
  int         m_sel;
  logic [1:0] m_player;

  c4_game_ctrl #(
    .START_COL (3),
    .WIN_LEN   (4)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .btn_left  (btn_left),
    .btn_right (btn_right),
    .btn_drop  (btn_drop),
    .step_tick (step_tick),
    .grid      (grid),
    .winner    (winner),
    .game_over (game_over),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  function automatic logic [97:0] cell_v(input int r, input int c, input logic [1:0] v);
    logic [97:0] g;
    g = '0;
    g[83 - 14 * r - 2 * c -: 2] = v;
    return g;
  endfunction

  function automatic logic [97:0] sel_v(input int c, input logic [1:0] v);
    logic [97:0] g;
    g = '0;
    g[97 - 2 * c -: 2] = v;
    return g;
  endfunction

  function automatic logic [97:0] board_v();
    logic [97:0] g;
    g = '0;
    for (int r = 0; r < 6; r++) begin
      for (int c = 0; c < 7; c++) begin
        g = g | cell_v(r, c, m_board[r][c]);
      end
    end
    return g;
  endfunction

  task automatic chk(input string tag, input logic [97:0] got, input logic [97:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic clear_model();
    for (int r = 0; r < 6; r++) begin
      for (int c = 0; c < 7; c++) begin
        m_board[r][c] = 2'b00;
      end
    end
    for (int c = 0; c < 7; c++) begin
      m_h[c] = 0;
    end
    m_sel    = 3;
    m_player = 2'b01;
  endtask

  task automatic reset_dut();
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    clear_model();
  endtask

  task automatic pulse(input logic l, input logic r, input logic d, input logic t);
    @(negedge clk);
    btn_left  = l;
    btn_right = r;
    btn_drop  = d;
    step_tick = t;
    @(negedge clk);
    btn_left  = 1'b0;
    btn_right = 1'b0;
    btn_drop  = 1'b0;
    step_tick = 1'b0;
  endtask

  task automatic goto_col(input int col);
    while (m_sel < col) begin
      pulse(1'b0, 1'b1, 1'b0, 1'b0);
      m_sel++;
    end
    while (m_sel > col) begin
      pulse(1'b1, 1'b0, 1'b0, 1'b0);
      m_sel--;
    end
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (busy && (n < 20)) begin
      @(negedge clk);
      n++;
    end
    chk("idle_timeout", {97'd0, busy}, 98'd0);
  endtask

  // Plays one move for the current model player; combo presses left together with drop.
  task automatic play(input int col, input logic combo);
    int row;
    goto_col(col);
    row = 5 - m_h[col];
    pulse(combo, 1'b0, 1'b1, 1'b0);
    chk("fall_start", grid, board_v() | cell_v(0, col, m_player));
    repeat (row + 1) pulse(1'b0, 1'b0, 1'b0, 1'b1);
    m_board[row][col] = m_player;
    m_h[col]++;
    wait_idle();
    m_player = m_player ^ 2'b11;
  endtask

  initial begin
    clear_model();
    rst_n = 1'b0;
    #12;
    chk("rst_grid", grid, sel_v(3, 2'b01));
    chk("rst_winner", {96'd0, winner}, 98'd0);
    chk("rst_game_over", {97'd0, game_over}, 98'd0);
    chk("rst_busy", {97'd0, busy}, 98'd0);
    reset_dut();

    // Selector moves right to the edge, then one more press at the edge.
    goto_col(6);
    chk("sel_col6", grid, sel_v(6, 2'b01));
    pulse(1'b0, 1'b1, 1'b0, 1'b0);
`ifdef C4_SELECT_WRAP_EN
    m_sel = 0;
`endif
    chk("sel_edge", grid, sel_v(m_sel, 2'b01));
    pulse(1'b1, 1'b1, 1'b0, 1'b0);
    chk("sel_both_no_move", grid, sel_v(m_sel, 2'b01));

    // Single drop at column 3 on an empty board, row by row.
    goto_col(3);
    pulse(1'b0, 1'b0, 1'b1, 1'b0);
    chk("fall_row0", grid, cell_v(0, 3, 2'b01));
    chk("fall_busy", {97'd0, busy}, 98'd1);
    for (int k = 1; k <= 5; k++) begin
      pulse(1'b0, 1'b0, 1'b0, 1'b1);
      chk("fall_row", grid, cell_v(k, 3, 2'b01));
    end
    pulse(1'b0, 1'b0, 1'b0, 1'b1);
    chk("landed", grid, cell_v(5, 3, 2'b01));
    repeat (3) @(negedge clk);
    chk("check_busy", {97'd0, busy}, 98'd1);
    @(negedge clk);
    chk("check_done_busy", {97'd0, busy}, 98'd0);
    chk("turn_p2", grid, cell_v(5, 3, 2'b01) | sel_v(3, 2'b10));
    m_board[5][3] = 2'b01;
    m_h[3]        = 1;
    m_player      = 2'b10;

    // Fill column 0, then a drop into the full column is ignored.
    for (int i = 0; i < 6; i++) begin
      play(0, 1'b0);
    end
    chk("col0_full", grid, board_v() | sel_v(0, m_player));
    pulse(1'b0, 1'b0, 1'b1, 1'b0);
    chk("full_drop_busy", {97'd0, busy}, 98'd0);
    chk("full_drop_grid", grid, board_v() | sel_v(0, m_player));

    // Horizontal win for player 1.
    reset_dut();
    play(0, 1'b0); play(6, 1'b0); play(1, 1'b0); play(6, 1'b0);
    play(2, 1'b0); play(6, 1'b0); play(3, 1'b0);
    chk("hwin_winner", {96'd0, winner}, 98'd1);
    chk("hwin_game_over", {97'd0, game_over}, 98'd1);
    chk("hwin_grid", grid, board_v());
    pulse(1'b1, 1'b0, 1'b0, 1'b0);
    pulse(1'b0, 1'b1, 1'b0, 1'b0);
    pulse(1'b0, 1'b0, 1'b0, 1'b1);
    chk("win_frozen_grid", grid, board_v());
    chk("win_frozen_winner", {96'd0, winner}, 98'd1);
    pulse(1'b0, 1'b0, 1'b1, 1'b0);
    clear_model();
    chk("restart_grid", grid, sel_v(3, 2'b01));
    chk("restart_winner", {96'd0, winner}, 98'd0);
    chk("restart_game_over", {97'd0, game_over}, 98'd0);

    // Vertical win for player 2; last drop pressed together with left.
    play(0, 1'b0); play(1, 1'b0); play(0, 1'b0); play(1, 1'b0);
    play(2, 1'b0); play(1, 1'b0); play(2, 1'b0); play(1, 1'b1);
    chk("vwin_winner", {96'd0, winner}, 98'd2);
    chk("vwin_grid", grid, board_v());
    pulse(1'b0, 1'b0, 1'b1, 1'b0);
    clear_model();

    // Up-right diagonal win for player 2.
    play(1, 1'b0); play(0, 1'b0); play(2, 1'b0); play(1, 1'b0); play(2, 1'b0);
    play(2, 1'b0); play(3, 1'b0); play(3, 1'b0); play(3, 1'b0); play(3, 1'b0);
    chk("dwin_winner", {96'd0, winner}, 98'd2);
    chk("dwin_game_over", {97'd0, game_over}, 98'd1);

    // Full board with no four-in-a-row ends in a draw.
    reset_dut();
    for (int p = 0; p < 3; p++) begin
      int a;
      int b;
      a = (p == 0) ? 0 : (p == 1) ? 1 : 4;
      b = (p == 0) ? 2 : (p == 1) ? 3 : 6;
      for (int q = 0; q < 3; q++) begin
        play(a, 1'b0); play(b, 1'b0); play(b, 1'b0); play(a, 1'b0);
      end
    end
    for (int i = 0; i < 6; i++) begin
      play(5, 1'b0);
    end
    chk("draw_game_over", {97'd0, game_over}, 98'd1);
    chk("draw_winner", {96'd0, winner}, 98'd0);
    chk("draw_grid", grid, board_v());

    // Restart, then reset in the middle of a fall.
    pulse(1'b0, 1'b0, 1'b1, 1'b0);
    clear_model();
    chk("draw_restart_grid", grid, sel_v(3, 2'b01));
    pulse(1'b0, 1'b0, 1'b1, 1'b0);
    pulse(1'b0, 1'b0, 1'b0, 1'b1);
    chk("midfall_row1", grid, cell_v(1, 3, 2'b01));
    #1;
    rst_n = 1'b0;
    #1;
    chk("midfall_rst_grid", grid, sel_v(3, 2'b01));
    chk("midfall_rst_busy", {97'd0, busy}, 98'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("after_rst_grid", grid, sel_v(3, 2'b01));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
